// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - UART receive FSM state encodings and line constants
// FSM encodings and line-level constants shared with the future uart_tx.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for asynchronous single-bit inputs
// RESET_VAL lets each user choose the flop reset level that matches its idle input state.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver on an oversample tick; UART_RX_PARITY_EN adds an even-parity bit
// All sampling decisions are taken on rx_en ticks from the synchronised line rx_s.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_nxt;
  logic                 rx_s;
  logic [SC_W-1:0]      sc;
  logic [BC_W-1:0]      bc;
  logic [DATA_BITS-1:0] shreg;
  logic                 sc_mid;
  logic                 sc_last;
  logic                 stop_ok;
  logic                 parity_ok;
  logic                 frame_done;
  logic                 frame_good;

  uart_sync2 #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign sc_mid  = (sc == SC_MID);
  assign sc_last = (sc == SC_LAST);
  assign stop_ok = (rx_s == LINE_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  // Even parity: data ones plus the parity bit must total an even count.
  assign parity_ok = ~(^shreg ^ par_bit);
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_done = rx_en && (state == STOP) && sc_last;
  assign frame_good = frame_done && stop_ok && parity_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (rx_en) begin
      case (state)
        IDLE:    if (!rx_s) state_nxt = START;
        START:   if (sc_mid) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        DATA:    if (sc_last && bc == BC_LAST) state_nxt = PARITY;
        PARITY:  if (sc_last) state_nxt = STOP;
`else
        DATA:    if (sc_last && bc == BC_LAST) state_nxt = STOP;
`endif
        // A low stop bit parks in BREAK so a held-low line cannot look like a new start bit.
        STOP:    if (sc_last) state_nxt = stop_ok ? IDLE : BREAK;
        BREAK:   if (rx_s) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    case (state)
      DATA, PARITY, STOP, BREAK: busy = 1'b1;
      default:                   busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc         <= '0;
      bc         <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      data_valid <= frame_good;
      frame_err  <= frame_done && !frame_good;
      if (frame_good) begin
        data_out <= shreg;
      end
      if (rx_en) begin
        case (state)
          START: begin
            sc <= sc_mid ? '0 : sc + 1'b1;
            bc <= '0;
          end
          DATA: begin
            if (sc_last) begin
              sc    <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              bc    <= (bc == BC_LAST) ? '0 : bc + 1'b1;
            end else begin
              sc <= sc + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (sc_last) begin
              par_bit <= rx_s;
            end
            sc <= sc_last ? '0 : sc + 1'b1;
          end
`endif
          STOP:    sc <= sc_last ? '0 : sc + 1'b1;
          default: sc <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (vector table, corner sequences, random frames)
module tb_uart_rx;

  localparam int OS  = 16;
  localparam int DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_en      (rx_en),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int div_cnt = 0;
  always @(negedge clk) begin
    if (div_cnt == DIV - 1) begin
      div_cnt = 0;
      rx_en   = 1'b1;
    end else begin
      div_cnt = div_cnt + 1;
      rx_en   = 1'b0;
    end
  end

  int   n_valid = 0;
  int   n_err = 0;
  int   n_both = 0;
  int   n_wide = 0;
  int   n_busy = 0;
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;
  always @(negedge clk) begin
    if (data_valid) n_valid = n_valid + 1;
    if (frame_err) n_err = n_err + 1;
    if (data_valid && frame_err) n_both = n_both + 1;
    if ((data_valid && prev_v) || (frame_err && prev_e)) n_wide = n_wide + 1;
    if (busy) n_busy = n_busy + 1;
    prev_v = data_valid;
    prev_e = frame_err;
  end

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (rx_en) k = k + 1;
    end
  endtask

  task automatic drive_bit(input logic b, input int ticks = OS);
    @(negedge clk);
    rx = b;
    wait_ticks(ticks);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop,
                            input int gap, output logic busy_mid);
    busy_mid = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i]);
      if (i == 3) #1 busy_mid = busy;
    end
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ !par_ok);
`endif
    drive_bit(stop);
    for (int g = 0; g < gap; g++) drive_bit(1'b1);
    #1;
  endtask

  // Reference rule: a byte is delivered only when its stop bit is high (and parity holds when enabled).
  function automatic bit model_good(input bit par_ok, input bit stop);
`ifdef UART_RX_PARITY_EN
    return stop && par_ok;
`else
    return stop;
`endif
  endfunction

  typedef struct {
    logic [7:0] d;
    bit         par_ok;
    bit         stop;
    int         gap;
    bit         exp_valid;
    logic [7:0] exp_dout;
  } vec_t;

  task automatic apply_vec(input vec_t v, input string tag);
    int   v0;
    int   e0;
    logic bm;
    v0 = n_valid;
    e0 = n_err;
    send_frame(v.d, v.par_ok, v.stop, v.gap, bm);
    check({tag, "_valid"}, n_valid - v0, {31'd0, v.exp_valid});
    check({tag, "_err"}, n_err - e0, {31'd0, !v.exp_valid});
    check({tag, "_dout"}, {24'd0, data_out}, {24'd0, v.exp_dout});
    check({tag, "_busy_mid"}, {31'd0, bm}, 32'd1);
    if (v.gap > 0) check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    if (v.exp_valid) exp_data = v.exp_dout;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[$];
    int         v0;
    int         e0;
    int         b0;
    logic [7:0] d;
    logic       bm;
    bit         st;
    bit         pk;
    int         gp;
    bit         good;

    vecs.push_back('{8'h55, 1'b1, 1'b1, 2, 1'b1, 8'h55});
    vecs.push_back('{8'hA5, 1'b1, 1'b1, 0, 1'b1, 8'hA5});
    vecs.push_back('{8'h3C, 1'b1, 1'b1, 2, 1'b1, 8'h3C});
    vecs.push_back('{8'h00, 1'b1, 1'b1, 1, 1'b1, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 1'b1, 1, 1'b1, 8'hFF});
    vecs.push_back('{8'h80, 1'b1, 1'b0, 2, 1'b0, 8'hFF});
    vecs.push_back('{8'h01, 1'b1, 1'b1, 1, 1'b1, 8'h01});

    repeat (4) @(negedge clk);
    check("rst_dout", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    drive_bit(1'b1, 2 * OS);

    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Short low pulse must be rejected at the mid start-bit check.
    v0 = n_valid; e0 = n_err; b0 = n_busy;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 2 * OS);
    #1;
    check("glitch_valid", n_valid - v0, 32'd0);
    check("glitch_err", n_err - e0, 32'd0);
    check("glitch_busy_cycles", n_busy - b0, 32'd0);
    apply_vec('{8'h5A, 1'b1, 1'b1, 1, 1'b1, 8'h5A}, "after_glitch");

    // Bad stop bit followed by a line held low for three bit times.
    v0 = n_valid; e0 = n_err; d = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(1'b0);
    drive_bit(1'b0, 3 * OS);
    #1;
    check("brk_err", n_err - e0, 32'd1);
    check("brk_valid", n_valid - v0, 32'd0);
    check("brk_dout", {24'd0, data_out}, {24'd0, exp_data});
    check("brk_busy", {31'd0, busy}, 32'd1);
    drive_bit(1'b1, 2 * OS);
    #1;
    check("brk_idle_busy", {31'd0, busy}, 32'd0);
    check("brk_quiet_err", n_err - e0, 32'd1);
    apply_vec('{8'h12, 1'b1, 1'b1, 2, 1'b1, 8'h12}, "after_brk");

    // Reset in the middle of bit 4 of 0x81.
    v0 = n_valid; e0 = n_err; d = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    drive_bit(d[4], OS / 2);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0; rx = 1'b1;
    exp_data = 8'h00;
    #1;
    check("rstmid_dout", {24'd0, data_out}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    wait_ticks(2 * OS);
    #1;
    check("rstmid_valid", n_valid - v0, 32'd0);
    check("rstmid_err", n_err - e0, 32'd0);
    apply_vec('{8'h81, 1'b1, 1'b1, 1, 1'b1, 8'h81}, "after_rst");

`ifdef UART_RX_PARITY_EN
    apply_vec('{8'h07, 1'b1, 1'b1, 1, 1'b1, 8'h07}, "par_ok");
    apply_vec('{8'h5A, 1'b1, 1'b1, 1, 1'b1, 8'h5A}, "par_ok2");
    apply_vec('{8'h07, 1'b0, 1'b1, 1, 1'b0, 8'h5A}, "par_bad");
    apply_vec('{8'hC3, 1'b0, 1'b0, 2, 1'b0, 8'h5A}, "par_bad_stop");
`endif

    for (int n = 0; n < 30; n++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      pk = ($urandom_range(0, 5) != 0);
      gp = st ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      good = model_good(pk, st);
      v0 = n_valid; e0 = n_err;
      send_frame(d, pk, st, gp, bm);
      if (good) exp_data = d;
      check($sformatf("rnd%0d_valid", n), n_valid - v0, {31'd0, good});
      check($sformatf("rnd%0d_err", n), n_err - e0, {31'd0, !good});
      check($sformatf("rnd%0d_dout", n), {24'd0, data_out}, {24'd0, exp_data});
    end

    drive_bit(1'b1, OS);
    check("never_both", n_both, 32'd0);
    check("one_clk_strobes", n_wide, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
